// File: rtl/axil_reg_station_fifo.sv
// AXI4-Lite register station: every channel runs through its own registered
// FIFO. Outstanding writes and reads are counted and capped, and per-transaction
// error flags ride in sideband FIFOs that force SLVERR on the matching response.

// Generic registered FIFO. Entries are flops so the head is always a register
// output, and the pointers wrap at DEPTH so non-power-of-2 depths also work.
module axil_reg_station_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    // Ready depends only on stored occupancy, never on a same-cycle pop.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage; cleared on reset so the idle output payload reads as zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // One register per entry, written when the write pointer selects it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem[gi] <= '0;
            else if (push && (wr_ptr == PW'(gi)))
                mem[gi] <= in_data;
        end
    end
endmodule

module axil_reg_station_fifo #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 err_write_i,
    input  logic                                 err_read_i,
    // Upstream (slave-side) channels
    input  logic [ADDR_WIDTH-1:0]                s_axi_awaddr,
    input  logic [2:0]                           s_axi_awprot,
    input  logic                                 s_axi_awvalid,
    output logic                                 s_axi_awready,
    input  logic [DATA_WIDTH-1:0]                s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]              s_axi_wstrb,
    input  logic                                 s_axi_wvalid,
    output logic                                 s_axi_wready,
    output logic [1:0]                           s_axi_bresp,
    output logic                                 s_axi_bvalid,
    input  logic                                 s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]                s_axi_araddr,
    input  logic [2:0]                           s_axi_arprot,
    input  logic                                 s_axi_arvalid,
    output logic                                 s_axi_arready,
    output logic [DATA_WIDTH-1:0]                s_axi_rdata,
    output logic [1:0]                           s_axi_rresp,
    output logic                                 s_axi_rvalid,
    input  logic                                 s_axi_rready,
    // Downstream (master-side) channels
    output logic [ADDR_WIDTH-1:0]                m_axi_awaddr,
    output logic [2:0]                           m_axi_awprot,
    output logic                                 m_axi_awvalid,
    input  logic                                 m_axi_awready,
    output logic [DATA_WIDTH-1:0]                m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]              m_axi_wstrb,
    output logic                                 m_axi_wvalid,
    input  logic                                 m_axi_wready,
    input  logic [1:0]                           m_axi_bresp,
    input  logic                                 m_axi_bvalid,
    output logic                                 m_axi_bready,
    output logic [ADDR_WIDTH-1:0]                m_axi_araddr,
    output logic [2:0]                           m_axi_arprot,
    output logic                                 m_axi_arvalid,
    input  logic                                 m_axi_arready,
    input  logic [DATA_WIDTH-1:0]                m_axi_rdata,
    input  logic [1:0]                           m_axi_rresp,
    input  logic                                 m_axi_rvalid,
    output logic                                 m_axi_rready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = DATA_WIDTH / 8;

    logic aw_in_ready, ar_in_ready;
    logic errw_in_ready, errr_in_ready;
    logic errw_out_valid, errr_out_valid;
    logic errw_out_data, errr_out_data;
    logic aw_hs, ar_hs, b_hs, r_hs;
    logic [1:0] b_push_resp, r_push_resp;

    // The err FIFOs never hold more than the outstanding count, so their ready
    // term only restates the outstanding cap; it keeps the sideband safe anyway.
    assign s_axi_awready = aw_in_ready & (wr_outstanding < OW'(MAX_OUTSTANDING)) & errw_in_ready;
    assign s_axi_arready = ar_in_ready & (rd_outstanding < OW'(MAX_OUTSTANDING)) & errr_in_ready;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign b_hs  = s_axi_bvalid & s_axi_bready;
    assign r_hs  = s_axi_rvalid & s_axi_rready;

    // An erroneous transaction still goes downstream; only its response is overridden.
    assign b_push_resp = (errw_out_valid & errw_out_data) ? 2'b10 : m_axi_bresp;
    assign r_push_resp = (errr_out_valid & errr_out_data) ? 2'b10 : m_axi_rresp;

    axil_reg_station_fifo_buf #(.WIDTH(ADDR_WIDTH + 3), .DEPTH(FIFO_DEPTH)) u_aw (
        .clk(aclk), .rst_n(aresetn),
        .in_data({s_axi_awaddr, s_axi_awprot}), .in_valid(aw_hs), .in_ready(aw_in_ready),
        .out_data({m_axi_awaddr, m_axi_awprot}), .out_valid(m_axi_awvalid), .out_ready(m_axi_awready)
    );

    axil_reg_station_fifo_buf #(.WIDTH(DATA_WIDTH + SW), .DEPTH(FIFO_DEPTH)) u_w (
        .clk(aclk), .rst_n(aresetn),
        .in_data({s_axi_wdata, s_axi_wstrb}), .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
        .out_data({m_axi_wdata, m_axi_wstrb}), .out_valid(m_axi_wvalid), .out_ready(m_axi_wready)
    );

    axil_reg_station_fifo_buf #(.WIDTH(2), .DEPTH(FIFO_DEPTH)) u_b (
        .clk(aclk), .rst_n(aresetn),
        .in_data(b_push_resp), .in_valid(m_axi_bvalid), .in_ready(m_axi_bready),
        .out_data(s_axi_bresp), .out_valid(s_axi_bvalid), .out_ready(s_axi_bready)
    );

    axil_reg_station_fifo_buf #(.WIDTH(ADDR_WIDTH + 3), .DEPTH(FIFO_DEPTH)) u_ar (
        .clk(aclk), .rst_n(aresetn),
        .in_data({s_axi_araddr, s_axi_arprot}), .in_valid(ar_hs), .in_ready(ar_in_ready),
        .out_data({m_axi_araddr, m_axi_arprot}), .out_valid(m_axi_arvalid), .out_ready(m_axi_arready)
    );

    axil_reg_station_fifo_buf #(.WIDTH(DATA_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_r (
        .clk(aclk), .rst_n(aresetn),
        .in_data({m_axi_rdata, r_push_resp}), .in_valid(m_axi_rvalid), .in_ready(m_axi_rready),
        .out_data({s_axi_rdata, s_axi_rresp}), .out_valid(s_axi_rvalid), .out_ready(s_axi_rready)
    );

    // Write error flags: pushed at upstream AW acceptance, popped when the
    // downstream B response is captured.
    axil_reg_station_fifo_buf #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_errw (
        .clk(aclk), .rst_n(aresetn),
        .in_data(err_write_i), .in_valid(aw_hs), .in_ready(errw_in_ready),
        .out_data(errw_out_data), .out_valid(errw_out_valid), .out_ready(m_axi_bvalid & m_axi_bready)
    );

    // Read error flags: same scheme keyed on AR acceptance and R capture.
    axil_reg_station_fifo_buf #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_errr (
        .clk(aclk), .rst_n(aresetn),
        .in_data(err_read_i), .in_valid(ar_hs), .in_ready(errr_in_ready),
        .out_data(errr_out_data), .out_valid(errr_out_valid), .out_ready(m_axi_rvalid & m_axi_rready)
    );

    // Outstanding counters: up on upstream request, down on upstream response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_outstanding <= '0;
            rd_outstanding <= '0;
        end else begin
            if (aw_hs && !b_hs)      wr_outstanding <= wr_outstanding + 1'b1;
            else if (!aw_hs && b_hs) wr_outstanding <= wr_outstanding - 1'b1;
            if (ar_hs && !r_hs)      rd_outstanding <= rd_outstanding + 1'b1;
            else if (!ar_hs && r_hs) rd_outstanding <= rd_outstanding - 1'b1;
        end
    end
endmodule
